// File: rtl/ahb_lite_sdram_arbiter_pkg.sv
// AHB-Lite encodings and arbiter FSM state type shared by the SDRAM front end.
package ahb_lite_defs;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } arb_state_e;

  function automatic int port_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ahb_lite_sdram_arbiter_rr_arbiter.sv
// rr_arbiter: rotate-priority find-first, first requester at or after rr_ptr wins.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter
  import ahb_lite_defs::*;
#(
  parameter  int N_PORTS   = 2,
  localparam int PORT_BITS = port_bits(N_PORTS)
) (
  input  logic [N_PORTS-1:0]   req,
  input  logic [PORT_BITS-1:0] rr_ptr,
  output logic                 grant_valid,
  output logic [PORT_BITS-1:0] grant_idx
);
  logic [PORT_BITS-1:0] idx;

  always_comb begin
    grant_valid = |req;
    grant_idx   = '0;
    idx         = '0;
    // Scan from the farthest offset inward so the nearest requester is written last.
    for (int off = N_PORTS - 1; off >= 0; off--) begin
      idx = PORT_BITS'((int'(rr_ptr) + off) % N_PORTS);
      if (req[idx]) grant_idx = idx;
    end
  end
endmodule

// File: rtl/ahb_lite_sdram_arbiter.sv
// ahb_lite_sdram_arbiter: round-robin req/ack ports serialised into single-word AHB-Lite NONSEQ transfers.
// Latency: address phase the cycle after grant; best-case ack three edges after req is sampled.
// Backpressure: HREADY low stretches address or data phase; requesters hold req until ack.
module ahb_lite_sdram_arbiter
  import ahb_lite_defs::*;
#(
  parameter  int N_PORTS    = 2,
  parameter  int HADDR_BITS = 25,
  localparam int PORT_BITS  = port_bits(N_PORTS)
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [N_PORTS-1:0]           req,
  input  logic [N_PORTS-1:0]           req_write,
  input  logic [N_PORTS*HADDR_BITS-1:0] req_addr,
  input  logic [N_PORTS*32-1:0]        req_wdata,
  output logic [N_PORTS-1:0]           ack,
  output logic [31:0]                  rdata,
  output logic                         err,
  output logic [PORT_BITS-1:0]         grant_id,
  output logic                         HSEL,
  output logic [HADDR_BITS-1:0]        HADDR,
  output logic [1:0]                   HTRANS,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic [2:0]                   HBURST,
  output logic [31:0]                  HWDATA,
  input  logic [31:0]                  HRDATA,
  input  logic                         HREADY,
  input  logic                         HRESP
);
  arb_state_e            state, state_nxt;
  logic [PORT_BITS-1:0]  rr_ptr, rr_ptr_nxt, grant_id_nxt, arb_idx;
  logic                  arb_vld;
  logic                  hsel_nxt, hwrite_nxt, err_nxt;
  logic [1:0]            htrans_nxt;
  logic [HADDR_BITS-1:0] haddr_nxt;
  logic [31:0]           wdata_hold, wdata_hold_nxt, hwdata_nxt, rdata_nxt;
  logic [N_PORTS-1:0]    ack_nxt;

  rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .grant_valid(arb_vld),
    .grant_idx  (arb_idx)
  );

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    grant_id_nxt   = grant_id;
    hsel_nxt       = HSEL;
    htrans_nxt     = HTRANS;
    hwrite_nxt     = HWRITE;
    haddr_nxt      = HADDR;
    hwdata_nxt     = HWDATA;
    wdata_hold_nxt = wdata_hold;
    rdata_nxt      = rdata;
    err_nxt        = err;
    ack_nxt        = '0;
    case (state)
      S_IDLE: begin
        hsel_nxt   = 1'b0;
        htrans_nxt = HTRANS_IDLE;
        if (arb_vld) begin
          grant_id_nxt   = arb_idx;
          haddr_nxt      = req_addr[int'(arb_idx)*HADDR_BITS +: HADDR_BITS];
          hwrite_nxt     = req_write[arb_idx];
          wdata_hold_nxt = req_wdata[int'(arb_idx)*32 +: 32];
          hsel_nxt       = 1'b1;
          htrans_nxt     = HTRANS_NONSEQ;
          state_nxt      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          hsel_nxt   = 1'b0;
          htrans_nxt = HTRANS_IDLE;
          hwdata_nxt = wdata_hold;
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          // HWRITE still holds the direction of the transfer being completed.
          if (!HWRITE) rdata_nxt = HRDATA;
          err_nxt           = HRESP;
          ack_nxt[grant_id] = 1'b1;
          rr_ptr_nxt        = (int'(grant_id) == N_PORTS - 1) ? '0 : grant_id + 1'b1;
          state_nxt         = S_GAP;
        end
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      HSEL       <= 1'b0;
      HTRANS     <= HTRANS_IDLE;
      HWRITE     <= 1'b0;
      HADDR      <= '0;
      HWDATA     <= '0;
      wdata_hold <= '0;
      ack        <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_id   <= grant_id_nxt;
      HSEL       <= hsel_nxt;
      HTRANS     <= htrans_nxt;
      HWRITE     <= hwrite_nxt;
      HADDR      <= haddr_nxt;
      HWDATA     <= hwdata_nxt;
      wdata_hold <= wdata_hold_nxt;
      ack        <= ack_nxt;
      rdata      <= rdata_nxt;
      err        <= err_nxt;
    end
  end
endmodule

// File: tb/tb_ahb_lite_sdram_arbiter.sv
// Bench for ahb_lite_sdram_arbiter: AHB slave with memory, req/ack requesters and a reference model.
module tb_ahb_lite_sdram_arbiter;
  import ahb_lite_defs::*;

  localparam int N  = 3;
  localparam int AW = 25;
  localparam int PB = 2;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [N-1:0]    req, req_write, ack;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0]     rdata, HWDATA, HRDATA;
  logic            err, HSEL, HWRITE, HREADY, HRESP;
  logic [PB-1:0]   grant_id;
  logic [AW-1:0]   HADDR;
  logic [1:0]      HTRANS;
  logic [2:0]      HSIZE, HBURST;

  always #5 HCLK = ~HCLK;

  ahb_lite_sdram_arbiter #(.N_PORTS(N), .HADDR_BITS(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .err(err), .grant_id(grant_id),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_chk = 0, n_pass = 0, cyc = 0, acks_seen = 0, last_ack_cyc = -1;
  // Reference model: last-served pointer, in-flight transaction, expected completion.
  int            model_ptr = 0, cur_port = -1, exp_ack_port = -1;
  logic [AW-1:0] cur_addr;
  logic          cur_write;
  logic [31:0]   cur_wdata;
  logic [31:0]   exp_rdata = '0;
  logic          exp_err = 1'b0;
  logic [31:0]   ref_mem [int];
  // Slave model state.
  bit            aphase = 0, dphase = 0, stable_ok = 1, dp_err = 0;
  int            aw_left = 0, dw_left = 0;
  logic [AW-1:0] ap_addr;
  logic          ap_write;
  logic [31:0]   slv_mem [int];
  // Scenario knobs.
  int            aw_min = 0, aw_max = 0, dw_min = 0, dw_max = 0, err_mode = 0;
  bit            rand_mode = 0, gap_chk = 0;
  logic [N-1:0]  cont_mask = '0;
  int            grant_log [$];
  int            exp_order [6] = '{0, 1, 0, 1, 0, 1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic new_txn(input int i);
    req[i]              = 1'b1;
    req_write[i]        = 1'($urandom_range(1, 0));
    req_addr[i*AW +: AW] = AW'($urandom_range(15, 0));
    req_wdata[i*32 +: 32] = $urandom;
  endtask

  task automatic set_txn(input int i, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*32 +: 32] = d;
    req[i]                = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0] req_seen;
    int           e;
    @(posedge HCLK);
    #1;
    cyc++;
    req_seen = req;
    // Completion: ack must appear exactly one cycle after the slave finished the data phase.
    if (ack !== '0 || exp_ack_port >= 0) begin
      check("ack", ack, (exp_ack_port >= 0) ? (64'd1 << exp_ack_port) : 64'd0);
      if (exp_ack_port >= 0) begin
        check("err", err, exp_err);
        check("rdata", rdata, exp_rdata);
        if (cont_mask[exp_ack_port]) new_txn(exp_ack_port);
        else req[exp_ack_port] = 1'b0;
        model_ptr    = (exp_ack_port + 1) % N;
        acks_seen++;
        last_ack_cyc = cyc;
        exp_ack_port = -1;
        cur_port     = -1;
      end
    end
    // New address phase: the winner is the first requester after the last served port.
    if (HTRANS === HTRANS_NONSEQ && !aphase) begin
      e = pick(req_seen, model_ptr);
      check("grant_id", grant_id, e);
      if (e >= 0) begin
        check("haddr", HADDR, req_addr[e*AW +: AW]);
        check("hwrite", HWRITE, req_write[e]);
        cur_port  = e;
        cur_addr  = req_addr[e*AW +: AW];
        cur_write = req_write[e];
        cur_wdata = req_wdata[e*32 +: 32];
      end
      check("hsel", HSEL, 1);
      if (gap_chk && last_ack_cyc >= 0) check("gap", cyc - last_ack_cyc, 2);
      grant_log.push_back(int'(grant_id));
      aphase    = 1;
      aw_left   = $urandom_range(aw_max, aw_min);
      stable_ok = 1;
      ap_addr   = HADDR;
      ap_write  = HWRITE;
    end
    // Slave: wait states, memory, response.
    HREADY = 1'($urandom_range(1, 0));
    HRESP  = 1'b0;
    HRDATA = $urandom;
    if (aphase) begin
      if (HADDR !== ap_addr || HWRITE !== ap_write || HTRANS !== HTRANS_NONSEQ || HSEL !== 1'b1)
        stable_ok = 0;
      if (aw_left > 0) begin
        HREADY = 1'b0;
        aw_left--;
      end else begin
        HREADY = 1'b1;
        check("aphase_stable", stable_ok, 1);
        aphase  = 0;
        dphase  = 1;
        dw_left = $urandom_range(dw_max, dw_min);
        dp_err  = (err_mode == 1) || (err_mode == 2 && $urandom_range(7, 0) == 0);
      end
    end else if (dphase) begin
      if (dw_left > 0) begin
        HREADY = 1'b0;
        dw_left--;
      end else begin
        HREADY = 1'b1;
        check("dphase_idle", {HSEL, HTRANS}, 0);
        if (ap_write) slv_mem[int'(ap_addr)] = HWDATA;
        else HRDATA = slv_mem.exists(int'(ap_addr)) ? slv_mem[int'(ap_addr)] : 32'h0;
        HRESP  = dp_err;
        dphase = 0;
        if (cur_port >= 0) begin
          if (cur_write) begin
            check("hwdata", HWDATA, cur_wdata);
            ref_mem[int'(cur_addr)] = cur_wdata;
          end else begin
            exp_rdata = ref_mem.exists(int'(cur_addr)) ? ref_mem[int'(cur_addr)] : 32'h0;
          end
          exp_err      = dp_err;
          exp_ack_port = cur_port;
        end
      end
    end
    // Random requesters: raise, abandon before grant, or scribble over a granted request.
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3, 0) == 0) new_txn(i);
        end else if (i != cur_port) begin
          if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          req_addr[i*AW +: AW]  = AW'($urandom);
          req_wdata[i*32 +: 32] = $urandom;
        end
      end
    end
  endtask

  task automatic apply_reset(input int n);
    HRESET = 1'b1;
    req    = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    repeat (n) begin
      @(posedge HCLK);
      #1;
      cyc++;
    end
    aphase = 0; dphase = 0;
    model_ptr = 0; cur_port = -1; exp_ack_port = -1; last_ack_cyc = -1;
    exp_rdata = '0; exp_err = 1'b0;
    grant_log.delete();
    HRESET = 1'b0;
  endtask

  task automatic run_acks(input int n, input int budget);
    int target;
    target = acks_seen + n;
    while (acks_seen < target && budget > 0) begin
      step();
      budget--;
    end
    if (acks_seen < target) check("ack_timeout", acks_seen, target);
  endtask

  initial begin
    int b;
    HRESET = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    apply_reset(2);
    check("rst_hsel", HSEL, 0);
    check("rst_htrans", HTRANS, HTRANS_IDLE);
    check("rst_hwrite", HWRITE, 0);
    check("rst_haddr", HADDR, 0);
    check("rst_hwdata", HWDATA, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_grant", grant_id, 0);
    check("hsize", HSIZE, 3'b010);
    check("hburst", HBURST, 3'b000);

    // Single write with three data-phase wait states.
    dw_min = 3; dw_max = 3;
    set_txn(0, 1'b1, 25'h0000123, 32'hDEADBEEF);
    run_acks(1, 50);
    check("wr_err", err, 0);

    // Read back on another port.
    dw_min = 0; dw_max = 0;
    set_txn(1, 1'b0, 25'h0000123, 32'h0);
    run_acks(1, 50);
    check("rd_back", rdata, 32'hDEADBEEF);

    // Address phase held for ten cycles.
    aw_min = 10; aw_max = 10;
    set_txn(2, 1'b1, 25'h0000456, 32'hCAFEF00D);
    run_acks(1, 60);
    aw_min = 0; aw_max = 0;

    // Error response, then a clean transfer.
    err_mode = 1;
    set_txn(0, 1'b0, 25'h0000123, 32'h0);
    run_acks(1, 50);
    check("err_set", err, 1);
    err_mode = 0;
    set_txn(0, 1'b0, 25'h0000456, 32'h0);
    run_acks(1, 50);
    check("err_clr", err, 0);
    check("rd_456", rdata, 32'hCAFEF00D);

    // Two ports requesting continuously from reset.
    apply_reset(1);
    gap_chk = 1;
    cont_mask = 3'b011;
    new_txn(0);
    new_txn(1);
    run_acks(6, 200);
    cont_mask = '0;
    req = '0;
    gap_chk = 0;
    check("order_cnt", grant_log.size(), 6);
    for (int k = 0; k < grant_log.size() && k < 6; k++) check("order", grant_log[k], exp_order[k]);

    // Reset while the data phase is stalled; the transfer is abandoned.
    dw_min = 5; dw_max = 5;
    set_txn(1, 1'b1, 25'h0000007, 32'h13579BDF);
    b = 0;
    while (!(dphase && dw_left < 3) && b < 50) begin
      step();
      b++;
    end
    check("midop_reached", dphase, 1);
    apply_reset(1);
    check("midop_htrans", HTRANS, HTRANS_IDLE);
    check("midop_hsel", HSEL, 0);
    check("midop_ack", ack, 0);
    check("midop_grant", grant_id, 0);
    dw_min = 0; dw_max = 0;
    set_txn(1, 1'b0, 25'h0000007, 32'h0);
    run_acks(1, 50);

    // Randomised traffic on all ports.
    rand_mode = 1; aw_min = 0; aw_max = 3; dw_min = 0; dw_max = 3; err_mode = 2;
    run_acks(80, 4000);
    rand_mode = 0; err_mode = 0;
    for (int i = 0; i < N; i++) if (i != cur_port) req[i] = 1'b0;
    b = 0;
    while ((cur_port >= 0 || aphase || dphase || exp_ack_port >= 0) && b < 100) begin
      step();
      b++;
    end
    check("drain", cur_port, -1);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
